// File: rtl/seq_booth_mult.sv
// rtl/seq_booth_mult.sv - sequential radix-2 Booth multiplier, 33-cycle latency
// Optional restart-on-start during RUN is enabled by defining MULT_ABORT_EN.

module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [3:0]       gb;
  logic [3:0]       pb;
  logic [3:0]       cb;
  logic             carry;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups; each group's carry-out is formed from generate/propagate terms
  always_comb begin
    carry = c_in;
    sum   = '0;
    gb    = '0;
    pb    = '0;
    cb    = '0;
    for (int k = 0; k < WIDTH / 4; k++) begin
      gb    = g[4*k +: 4];
      pb    = p[4*k +: 4];
      cb[0] = carry;
      cb[1] = gb[0] | (pb[0] & carry);
      cb[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & carry);
      cb[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) | (pb[2] & pb[1] & pb[0] & carry);
      sum[4*k +: 4] = pb ^ cb;
      carry = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) |
              (pb[3] & pb[2] & pb[1] & gb[0]) | ((&pb) & carry);
    end
    c_out = carry;
  end

endmodule

module seq_booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [2*WIDTH:0] product;
  logic [2*WIDTH:0] step_product;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             sub;
  logic             step_active;
  logic             c_out;
  logic             sum_sign;
  logic             start_accept;

`ifdef MULT_ABORT_EN
  assign start_accept = ctrl_MULT && (state == IDLE || state == RUN);
`else
  assign start_accept = ctrl_MULT && (state == IDLE);
`endif

  assign sub         = product[1] & ~product[0];
  assign step_active = product[1] ^ product[0];
  assign addend      = sub ? ~multiplicand : multiplicand;

  cla_adder #(.WIDTH(WIDTH)) u_cla (
    .a     (product[2*WIDTH:WIDTH+1]),
    .b     (addend),
    .c_in  (sub),
    .sum   (sum),
    .c_out (c_out)
  );

  // Shift in the true 33rd sum bit so 0 - (-2^31) does not wrap negative
  assign sum_sign     = product[2*WIDTH] ^ addend[WIDTH-1] ^ c_out;
  assign step_product = step_active ? {sum_sign, sum, product[WIDTH:1]}
                                    : {product[2*WIDTH], product[2*WIDTH:1]};

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_MULT) state_next = RUN;
      RUN:     if (!start_accept && count == LAST_STEP) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count          <= '0;
      product        <= '0;
      multiplicand   <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start_accept) begin
        multiplicand <= data_operandA;
        product      <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
        count        <= '0;
      end else if (state == RUN) begin
        product <= step_product;
        count   <= count + 1'b1;
      end
      // Result registers hold until the next operation reaches DONE
      if (state == DONE) begin
        data_result    <= product[WIDTH:1];
        data_exception <= (product[2*WIDTH:WIDTH+1] != {WIDTH{product[WIDTH]}});
        data_resultRDY <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// tb/tb_seq_booth_mult.sv - self-checking bench for seq_booth_mult
module tb_seq_booth_mult;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total;
  int bad;

  seq_booth_mult #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    r  = p[31:0];
    e  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  // Called at a negedge; start edge is the next posedge. Cycle c is the one beginning at edge c.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int rdy_at, output int pulses, output logic [31:0] res,
                       output logic exc, output int busy_low, output logic [31:0] held);
    ctrl_MULT = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    rdy_at = -1; pulses = 0; res = '0; exc = 1'b0; busy_low = 0;
    for (int c = 0; c < 45; c++) begin
      if (data_resultRDY) begin
        pulses++;
        if (rdy_at < 0) begin
          rdy_at = c;
          res = data_result;
          exc = data_exception;
        end
      end
      if (c < 33 && !busy) busy_low++;
      @(negedge clock);
    end
    held = data_result;
  endtask

  task automatic test_reset();
    int rdy_at, pulses, busy_low;
    logic [31:0] res, held;
    logic exc;
    reset_n = 1'b0; ctrl_MULT = 1'b0; data_operandA = 32'd3; data_operandB = 32'd4;
    #2;
    total++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      bad++; $display("FAIL reset_outputs: got %h expected 0", {data_result, data_exception, data_resultRDY, busy});
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    do_op(32'd3, 32'd4, rdy_at, pulses, res, exc, busy_low, held);
    total++;
    if (rdy_at !== 33) begin bad++; $display("FAIL first_start_latency: got %0d expected 33", rdy_at); end
    total++;
    if (res !== 32'h0000000C || exc !== 1'b0) begin
      bad++; $display("FAIL first_start_result: got %h/%b expected 0000000c/0", res, exc);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'd3, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h40000000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] tb [7] = '{32'd4, 32'd6,        32'hFFFFFFFF, 32'd4,        32'hFFFFFFFF, 32'd1,        32'h7FFFFFFF};
    logic [31:0] tr [7] = '{32'hC, 32'hFFFFFFD6, 32'd1,        32'd0,        32'h80000000, 32'h80000000, 32'd1};
    logic        te [7] = '{1'b0,  1'b0,         1'b0,         1'b1,         1'b1,         1'b0,         1'b1};
    int rdy_at, pulses, busy_low;
    logic [31:0] res, held;
    logic exc;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], rdy_at, pulses, res, exc, busy_low, held);
      total++;
      if (rdy_at !== 33 || pulses !== 1) begin
        bad++; $display("FAIL directed_timing[%0d]: rdy_at=%0d pulses=%0d expected 33/1", i, rdy_at, pulses);
      end
      total++;
      if (res !== tr[i] || exc !== te[i]) begin
        bad++; $display("FAIL directed_result[%0d]: got %h/%b expected %h/%b", i, res, exc, tr[i], te[i]);
      end
      total++;
      if (busy_low !== 0 || held !== tr[i]) begin
        bad++; $display("FAIL directed_busy_hold[%0d]: busy_low=%0d held=%h expected 0/%h", i, busy_low, held, tr[i]);
      end
    end
  endtask

  task automatic test_random();
    int rdy_at, pulses, busy_low;
    logic [31:0] res, held, a, b, er;
    logic exc, ee;
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0:       begin a = $urandom; b = $urandom; end
        1:       begin a = 32'($signed(16'($urandom))); b = 32'($signed(16'($urandom))); end
        default: begin a = $urandom_range(0, 9) - 5; b = $urandom; end
      endcase
      model(a, b, er, ee);
      do_op(a, b, rdy_at, pulses, res, exc, busy_low, held);
      total++;
      if (rdy_at !== 33 || res !== er || exc !== ee || held !== er) begin
        bad++; $display("FAIL random[%0d] %h*%h: rdy_at=%0d got %h/%b expected %h/%b", i, a, b, rdy_at, res, exc, er, ee);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses, rdy_at, busy_low;
    logic [31:0] res, held;
    logic exc;
    ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd5;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      bad++; $display("FAIL reset_mid_run_outputs: got %h expected 0", {data_result, data_exception, data_resultRDY, busy});
    end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (c == 2) reset_n = 1'b1;
      if (data_resultRDY) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL reset_mid_run_no_rdy: pulses=%0d expected 0", pulses); end
    do_op(32'd2, 32'd3, rdy_at, pulses, res, exc, busy_low, held);
    total++;
    if (rdy_at !== 33 || res !== 32'd6 || exc !== 1'b0) begin
      bad++; $display("FAIL after_reset_op: rdy_at=%0d got %h/%b expected 33/00000006/0", rdy_at, res, exc);
    end
  endtask

  task automatic test_start_during_run();
    int rdy_at, pulses;
    logic [31:0] res;
    ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd5;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    rdy_at = -1; pulses = 0; res = '0;
    for (int c = 0; c < 60; c++) begin
      if (data_resultRDY) begin
        pulses++;
        if (rdy_at < 0) begin rdy_at = c; res = data_result; end
      end
      if (c == 9) begin
        ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
      end else begin
        ctrl_MULT = 1'b0;
      end
      @(negedge clock);
    end
`ifdef MULT_ABORT_EN
    total++;
    if (rdy_at !== 43 || res !== 32'd81 || pulses !== 1) begin
      bad++; $display("FAIL restart_run: rdy_at=%0d res=%0d pulses=%0d expected 43/81/1", rdy_at, res, pulses);
    end
`else
    total++;
    if (rdy_at !== 33 || res !== 32'd25 || pulses !== 1) begin
      bad++; $display("FAIL ignore_start_run: rdy_at=%0d res=%0d pulses=%0d expected 33/25/1", rdy_at, res, pulses);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int rdy_cyc [$];
    logic [31:0] rdy_res [$];
    int busy_low_cnt, busy_low_first;
    logic [31:0] a2, b2, er1, er2;
    logic ee;
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    model(32'hFFFFF000, 32'd77, er1, ee);
    model(a2, b2, er2, ee);
    ctrl_MULT = 1'b1; data_operandA = 32'hFFFFF000; data_operandB = 32'd77;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    busy_low_cnt = 0; busy_low_first = -1;
    for (int c = 0; c < 80; c++) begin
      if (data_resultRDY) begin rdy_cyc.push_back(c); rdy_res.push_back(data_result); end
      if (c < 67 && !busy) begin
        busy_low_cnt++;
        if (busy_low_first < 0) busy_low_first = c;
      end
      if (c == 32) begin
        ctrl_MULT = 1'b1; data_operandA = a2; data_operandB = b2;
      end else if (c == 34) begin
        ctrl_MULT = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
      end
      @(negedge clock);
    end
    total++;
    if (rdy_cyc.size() !== 2) begin
      bad++; $display("FAIL b2b_pulses: got %0d expected 2", rdy_cyc.size());
    end else begin
      total++;
      if (rdy_cyc[0] !== 33 || rdy_res[0] !== er1) begin
        bad++; $display("FAIL b2b_first: cycle=%0d res=%h expected 33/%h", rdy_cyc[0], rdy_res[0], er1);
      end
      total++;
      if (rdy_cyc[1] !== 67 || rdy_res[1] !== er2) begin
        bad++; $display("FAIL b2b_second: cycle=%0d res=%h expected 67/%h", rdy_cyc[1], rdy_res[1], er2);
      end
    end
    total++;
    if (busy_low_cnt !== 1 || busy_low_first !== 33) begin
      bad++; $display("FAIL b2b_busy: low_cycles=%0d first_low=%0d expected 1/33", busy_low_cnt, busy_low_first);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_run();
    test_start_during_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_booth_mult.md
SEQ_BOOTH_MULT -- requirements
Module: seq_booth_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits; only 32 is supported.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ctrl_MULT  input  1  start pulse; operands are sampled on the same edge.
REQ-005 SHALL have port data_operandA  input  32  signed multiplicand.
REQ-006 SHALL have port data_operandB  input  32  signed multiplier.
REQ-007 SHALL have port data_result  output  32  low 32 bits of the signed product.
REQ-008 SHALL have port data_exception  output  1  product does not fit in 32-bit signed; valid with data_resultRDY.
REQ-009 SHALL have port data_resultRDY  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.

Function
REQ-011 SHALL implement the states IDLE, RUN and DONE; reset enters IDLE.
REQ-012 SHALL, in IDLE with ctrl_MULT=1, latch A into the multiplicand register, load the product register as {32'b0, B, 1'b0}, clear the step counter, and enter RUN.
REQ-013 SHALL, in each RUN cycle, examine product bits [1:0]: 01 adds A into the upper half, 10 subtracts A (adds ~A plus carry-in 1), 00 and 11 leave it unchanged; it then arithmetic-shifts the 65-bit register right by 1.
REQ-014 SHALL perform the add/subtract with the team's 32-bit carry-lookahead adder, using its c_in for the subtract carry.
REQ-015 SHALL exit RUN after exactly 32 steps (counter values 0..31) and enter DONE.
REQ-016 SHALL, in DONE, drive data_resultRDY=1 for exactly one cycle, then return to IDLE.
REQ-017 SHALL give a latency of 33 cycles: data_resultRDY is high in the cycle that begins at rising edge 33 after the start edge.
REQ-018 SHALL drive data_result from product[32:1], the low word.
REQ-019 SHALL set data_exception to 1 when product[64:33] is not all equal to product[32], i.e. the upper word is not the sign extension of the low word.
REQ-020 SHALL hold data_result and data_exception stable from DONE until the next start is accepted.
REQ-021 SHALL drive busy=1 in RUN and in DONE, and 0 in IDLE.
REQ-022 SHALL ignore ctrl_MULT in DONE.
REQ-023 SHALL ignore operand changes after the start edge.
REQ-024 SHALL handle the boundary operands without special casing: 0x80000000*0xFFFFFFFF raises exception with result 0x80000000; 0x80000000*1 gives 0x80000000 with no exception.

Reset
REQ-025 SHALL, when reset_n=0, immediately and asynchronously force state=IDLE, counter=0, product=0, multiplicand=0, data_result=0, data_exception=0, data_resultRDY=0 and busy=0.
REQ-026 SHALL, when reset is asserted mid-RUN, abandon the operation; no data_resultRDY pulse is produced.
REQ-027 SHALL accept the first start on the first rising edge after reset_n deasserts.

Configuration
REQ-028 SHALL, with MULT_ABORT_EN defined, treat ctrl_MULT=1 during RUN as a restart: it recaptures the operands, resets the counter, and the result arrives 33 cycles after the restart edge.
REQ-029 SHALL, without MULT_ABORT_EN, ignore ctrl_MULT during RUN and complete the current operation unchanged.

Verification
REQ-030 SHALL cover: A=3, B=4, pulse start -> at cycle 33, resultRDY=1, result=0x0000000C, exception=0.
REQ-031 SHALL cover: A=-7, B=6 -> result=0xFFFFFFD6 (-42), exception=0; A=-1, B=-1 -> result=1, exception=0.
REQ-032 SHALL cover: A=0x40000000, B=4 -> result=0x00000000, exception=1; A=0x80000000, B=-1 -> result=0x80000000, exception=1.
REQ-033 SHALL cover: start 5*5, assert reset_n=0 at cycle 10 -> outputs 0 immediately, no resultRDY; then 2*3 -> result=6 at cycle 33 after its start.
REQ-034 SHALL cover: start 5*5, pulse start 9*9 at cycle 10 -> with MULT_ABORT_EN, result=81 at cycle 43; without it, result=25 at cycle 33 and no second pulse.
REQ-035 SHALL cover: back-to-back starts -> the start in the cycle after DONE is accepted, with busy low only in that IDLE cycle.
